// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: sequences one DSP48A1 slice through an N-element stall-aligned multiply-accumulate
module dsp_mac_sequencer #(
  parameter int WIDTH_LEN = 8,
  parameter int PIPE_LAT = 4,
  parameter logic [7:0] OPMODE_FIRST = 8'b0000_0001,
  parameter logic [7:0] OPMODE_ACC = 8'b0000_1001
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [WIDTH_LEN-1:0] Len,
  input  logic                 Abort,
  input  logic                 Op_valid,
  output logic                 Op_ready,
  output logic                 Ce_ab,
  output logic                 Ce_m,
  output logic                 Ce_p,
  output logic [7:0]           Opmode,
  output logic                 Rst_p,
  output logic                 Busy,
  output logic                 Done
);
  localparam int DW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT - 1) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH_LEN-1:0] len_q, count;
  logic [DW-1:0] dcnt;
  logic [PIPE_LAT-1:1] tag_v, tag_f;
  logic abort_q, accept, advance, last, kill;
  always_comb begin
    kill = Abort & (state != IDLE);
    Op_ready = state == RUN;
    accept = Op_valid & Op_ready;
    advance = (state == RUN) ? accept : (state == DRAIN);
    last = accept & (count + 1'b1 == len_q);
    Ce_ab = accept;
    Ce_m = advance;
    Ce_p = advance & tag_v[PIPE_LAT-1];
    Opmode = tag_f[PIPE_LAT-1] ? OPMODE_FIRST : OPMODE_ACC;
    Rst_p = (state == CLEAR) | abort_q;
    Busy = state != IDLE;
    Done = (state == DONE) & ~Abort;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = Start ? ((Len == '0) ? CLEAR : RUN) : IDLE;
      CLEAR:   state_nxt = DONE;
      RUN:     state_nxt = last ? DRAIN : RUN;
      DRAIN:   state_nxt = (dcnt == DW'(PIPE_LAT - 2)) ? DONE : DRAIN;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end
  // Tags shift only on advance so they stay aligned with the frozen slice registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      len_q <= '0;
      count <= '0;
      dcnt <= '0;
      tag_v <= '0;
      tag_f <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_nxt;
      abort_q <= kill;
      if (state == IDLE && Start) begin
        len_q <= Len;
        count <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (kill) begin
        tag_v <= '0;
        tag_f <= '0;
      end else if (advance) begin
        for (int k = PIPE_LAT - 1; k > 1; k--) begin
          tag_v[k] <= tag_v[k-1];
          tag_f[k] <= tag_f[k-1];
        end
        tag_v[1] <= accept;
        tag_f[1] <= count == '0;
      end
    end
  end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1 slice through an N-element multiply-accumulate (dot product).
- Accepts operand pairs over a valid/ready handshake and drives the slice's A/B, M and P clock enables, OPMODE and P-register reset.
- The slice's internal Reg_Mux stages (A/B, M, P registered) run stall-aligned with the stream.
- Signals Done when P holds the final sum.
- Sits between the operand source and the DSP48A1 top.

Parameters:
- WIDTH_LEN, 8, width of the element-count input.
- PIPE_LAT, 4, number of slice register stages from operand capture to P update; legal range 2..16.
- OPMODE_FIRST, 8'b0000_0001, OPMODE for the first element: X=M, Z=0, loads the product.
- OPMODE_ACC, 8'b0000_1001, OPMODE for later elements: X=M, Z=P, accumulates.

Ports:
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Start  in  1  begin a job; sampled only in IDLE.
- Len  in  WIDTH_LEN  element count; captured on Start.
- Abort  in  1  cancel the current job.
- Op_valid  in  1  operand pair present on the slice A/B inputs.
- Op_ready  out  1  sequencer accepts an operand pair this cycle.
- Ce_ab  out  1  CEA/CEB to the slice.
- Ce_m  out  1  CEM to the slice.
- Ce_p  out  1  CEP to the slice.
- Opmode  out  8  OPMODE to the slice.
- Rst_p  out  1  synchronous reset to the slice P register.
- Busy  out  1  high whenever state is not IDLE.
- Done  out  1  one-cycle pulse; slice P output is valid.

Behaviour:
- Reset (Rst low):
  - State returns to IDLE and all tags are cleared.
  - All outputs are 0, except Opmode = OPMODE_ACC.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- Terminology:
  - accept = Op_valid & Op_ready.
  - Op_ready = (state == RUN).
  - advance = accept in RUN, 1 in DRAIN, 0 otherwise.
- Tag pipe: T[1..PIPE_LAT-1], each tag = {valid, first}.
  - On advance: T[1] <= {accept, count == 0}, and T[k] <= T[k-1].
  - When advance is 0, tags hold.
- Enable outputs (combinational from state and tags):
  - Ce_ab = accept.
  - Ce_m = advance.
  - Ce_p = advance & T[PIPE_LAT-1].valid.
  - Opmode = OPMODE_FIRST when T[PIPE_LAT-1].first, else OPMODE_ACC.
- Element counter: cleared on Start, incremented on each accept.
- IDLE:
  - Start & Len != 0: capture Len, go to RUN.
  - Start & Len == 0: go to CLEAR.
- CLEAR: Rst_p = 1 for one cycle, then go to DONE. The result is 0.
- RUN:
  - Waits indefinitely while Op_valid is low; the pipeline freezes with all CEs low.
  - The accept that makes count == Len moves the state to DRAIN.
- DRAIN: lasts exactly PIPE_LAT-1 cycles with advance = 1, then goes to DONE.
- DONE: Done = 1 for one cycle, then IDLE. Slice P output holds until the next job.
- Latency:
  - Let the first accept be at cycle c with no stalls.
  - Ce_p is high on cycles c+PIPE_LAT-1 through c+N+PIPE_LAT-2.
  - Done is high at cycle c+N+PIPE_LAT-1.
  - Each stall cycle adds one cycle.
- Start outside IDLE is ignored, and Len changes outside IDLE are ignored.
- Abort in CLEAR/RUN/DRAIN/DONE:
  - Next cycle the state is IDLE, all tags are cleared and Rst_p = 1 for that cycle.
  - Done is not pulsed.
- Abort has priority over simultaneous accept and over the DRAIN-to-DONE transition.
- Abort in IDLE is ignored.
- Rst asserted mid-job: immediate return to IDLE with outputs at reset values. The slice P register is not cleared by this block.
- Len = 2^WIDTH_LEN - 1: the counter is WIDTH_LEN bits wide and must not wrap before the compare.

Test Plan:
- Len=4, PIPE_LAT=4, Op_valid held high from cycle c -> Op_ready high c..c+3; Ce_p high c+3..c+6; Opmode=OPMODE_FIRST only at c+3; Done at c+7; P = Σ A·B for A={1,2,3,4}, B={5,6,7,8}, i.e. 70.
- Same job with Op_valid low for 2 cycles after the 2nd accept -> Ce_ab/Ce_m/Ce_p all 0 during the gap; Done at c+9; P = 70.
- Start with Len=0 -> Rst_p high the next cycle, Done the cycle after that; P = 0; Op_ready never high.
- Abort during the 2nd DRAIN cycle of a Len=3 job -> IDLE next cycle; Rst_p pulse; no Done; a new Len=1 job with A=3, B=4 yields P=12.
- Start pulsed in RUN with a different Len -> ignored; the job completes with the original Len.
- Rst driven low mid-RUN asynchronously -> Busy, Op_ready, CEs drop without waiting for a clock edge; after release, a Len=1 job completes normally.
